// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: N masters share one slave port, grant held for the cyc lock.
// A watchdog answers a stalled strobe with a generated err after TIMEOUT_CYCLES.
module wb_rr_arbiter #(
    parameter int N_MASTERS      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_cyc,
    input  logic [N_MASTERS-1:0]          m_stb,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [32*N_MASTERS-1:0]       m_adr,
    input  logic [32*N_MASTERS-1:0]       m_dat_w,
    input  logic [4*N_MASTERS-1:0]        m_sel,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic [31:0]                   m_dat_r,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [31:0]                   s_adr,
    output logic [31:0]                   s_dat_w,
    output logic [3:0]                    s_sel,
    input  logic                          s_ack,
    input  logic                          s_err,
    input  logic [31:0]                   s_dat_r,
    output logic [$clog2(N_MASTERS)-1:0]  grant,
    output logic                          busy
);

    localparam int GW = $clog2(N_MASTERS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last;
    logic [TW-1:0]   r_tmo_cnt;

    logic            w_busy;
    logic            w_any;
    logic [GW-1:0]   w_winner;
    int              w_dist;
    int              w_best;
    logic            w_cyc_g;
    logic            w_stb_g;
    logic            w_we_g;
    logic [31:0]     w_adr_g;
    logic [31:0]     w_dat_g;
    logic [3:0]      w_sel_g;
    logic            w_stall;
    logic            w_tmo_hit;

    assign w_busy  = (r_state == ST_BUSY);
    assign w_any   = |m_cyc;
    assign busy    = w_busy;
    assign grant   = r_grant;
    assign m_dat_r = s_dat_r;

    // Winner is the requester closest after r_last in circular order.
    always_comb begin
        w_winner = r_last;
        w_best   = N_MASTERS;
        w_dist   = 0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (m_cyc[j]) begin
                w_dist = (j + N_MASTERS - 1 - int'(r_last)) % N_MASTERS;
                if (w_dist < w_best) begin
                    w_best   = w_dist;
                    w_winner = GW'(j);
                end
            end
        end
    end

    always_comb begin
        w_cyc_g = 1'b0;
        w_stb_g = 1'b0;
        w_we_g  = 1'b0;
        w_adr_g = '0;
        w_dat_g = '0;
        w_sel_g = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (r_grant == GW'(j)) begin
                w_cyc_g = m_cyc[j];
                w_stb_g = m_stb[j];
                w_we_g  = m_we[j];
                w_adr_g = m_adr[32*j +: 32];
                w_dat_g = m_dat_w[32*j +: 32];
                w_sel_g = m_sel[4*j +: 4];
            end
        end
    end

    assign s_cyc   = w_busy & w_cyc_g;
    assign s_stb   = s_cyc & w_stb_g;
    assign s_we    = w_busy & w_we_g;
    assign s_adr   = w_busy ? w_adr_g : '0;
    assign s_dat_w = w_busy ? w_dat_g : '0;
    assign s_sel   = w_busy ? w_sel_g : '0;

    // A real ack in the limit cycle suppresses the generated err.
    assign w_stall   = s_stb & ~s_ack & ~s_err;
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && w_stall && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (w_busy) begin
            for (int j = 0; j < N_MASTERS; j++) begin
                if (r_grant == GW'(j)) begin
                    m_ack[j] = s_ack;
                    m_err[j] = s_err | w_tmo_hit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= GW'(N_MASTERS - 1);
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_any) begin
                        r_state <= ST_BUSY;
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                    end
                end
                ST_BUSY: begin
                    if (!w_cyc_g) begin
                        r_state   <= ST_IDLE;
                        r_tmo_cnt <= '0;
                    end else if (w_stall && !w_tmo_hit && (TIMEOUT_CYCLES != 0)) begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end else begin
                        r_tmo_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios, literal checks, and a
// per-cycle comparison against a behavioural ownership/stall model.
module tb_wb_rr_arbiter;

    localparam int N   = 3;
    localparam int TMO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [32*N-1:0]   m_adr, m_dat_w;
    logic [4*N-1:0]    m_sel;
    logic [N-1:0]      m_ack, m_err;
    logic [31:0]       m_dat_r;
    logic              s_cyc, s_stb, s_we;
    logic [31:0]       s_adr, s_dat_w;
    logic [3:0]        s_sel;
    logic              s_ack, s_err;
    logic [31:0]       s_dat_r;
    logic [1:0]        grant;
    logic              busy;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
        .grant(grant), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        return |(v & (N'(1) << i));
    endfunction

    // Model: who owns the bus (-1 = nobody), who won last, and how long the strobe has stalled.
    int mo_owner = -1;
    int mo_last  = N - 1;
    int mo_grant = 0;
    int mo_stall = 0;

    always @(posedge clk) begin
        if (!rst) begin
            mo_owner = -1;
            mo_last  = N - 1;
            mo_grant = 0;
            mo_stall = 0;
        end else if (mo_owner < 0) begin
            mo_stall = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mo_last + k) % N;
                if (mo_owner < 0 && bit_of(m_cyc, c)) begin
                    mo_owner = c;
                    mo_last  = c;
                    mo_grant = c;
                end
            end
        end else if (!bit_of(m_cyc, mo_owner)) begin
            mo_owner = -1;
            mo_stall = 0;
        end else if (bit_of(m_stb, mo_owner) && !s_ack && !s_err) begin
            mo_stall = (mo_stall == TMO) ? 0 : mo_stall + 1;
        end else begin
            mo_stall = 0;
        end
    end

    logic [N-1:0] e_ack, e_err, e_oh;
    logic         e_busy, e_cyc, e_stb;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = (mo_owner >= 0);
            e_ack  = '0;
            e_err  = '0;
            e_oh   = '0;
            e_cyc  = 1'b0;
            e_stb  = 1'b0;
            if (e_busy) begin
                e_oh  = N'(1) << mo_owner;
                e_cyc = bit_of(m_cyc, mo_owner);
                e_stb = e_cyc && bit_of(m_stb, mo_owner);
                if (s_ack) e_ack = e_oh;
                if (s_err || (e_stb && !s_ack && !s_err && mo_stall == TMO)) e_err = e_oh;
            end
            check("mdl_busy",  32'(busy),  32'(e_busy));
            check("mdl_s_cyc", 32'(s_cyc), 32'(e_cyc));
            check("mdl_s_stb", 32'(s_stb), 32'(e_stb));
            check("mdl_m_ack", 32'(m_ack), 32'(e_ack));
            check("mdl_m_err", 32'(m_err), 32'(e_err));
            check("mdl_m_dat_r", m_dat_r, s_dat_r);
            if (e_busy) begin
                check("mdl_grant",   32'(grant),   32'(mo_grant));
                check("mdl_s_we",    32'(s_we),    32'(bit_of(m_we, mo_owner)));
                check("mdl_s_adr",   s_adr,        32'(m_adr >> (32 * mo_owner)));
                check("mdl_s_dat_w", s_dat_w,      32'(m_dat_w >> (32 * mo_owner)));
                check("mdl_s_sel",   32'(s_sel),   32'(4'(m_sel >> (4 * mo_owner))));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_dat_w = '0;
        m_sel   = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat_r = 32'hCAFE_0000;

        // Reset state
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        step();
        rst = 1'b1;

        // All three request: grants 0,1,2,0 with one idle cycle after each release
        m_cyc = 3'b111;
        step();
        for (int i = 0; i < 4; i++) begin
            int g;
            g = i % N;
            m_cyc[g] = 1'b0;
            @(negedge clk);
            check("rr_grant", 32'(grant), 32'(g));
            check("rr_busy",  32'(busy),  32'd1);
            step();
            m_cyc[g] = 1'b1;
            @(negedge clk);
            check("rr_gap_busy",  32'(busy),  32'd0);
            check("rr_gap_s_cyc", 32'(s_cyc), 32'd0);
            step();
        end
        m_cyc = '0;
        step();

        // Master 1 read at 0x40, slave acks on the third cycle
        m_cyc = 3'b010;
        m_stb = 3'b010;
        m_adr[63:32] = 32'h0000_0040;
        m_sel[7:4]   = 4'hF;
        step();
        @(negedge clk);
        check("rd_grant", 32'(grant), 32'd1);
        check("rd_s_adr", s_adr, 32'h0000_0040);
        check("rd_ack_early", 32'(m_ack), 32'd0);
        step();
        @(negedge clk);
        check("rd_ack_early", 32'(m_ack), 32'd0);
        step();
        s_ack   = 1'b1;
        s_dat_r = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_m_ack",   32'(m_ack), 32'b010);
        check("rd_m_dat_r", m_dat_r,    32'hDEAD_BEEF);
        step();
        s_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        @(negedge clk);
        check("rd_ack_once", 32'(m_ack), 32'd0);
        step();

        // Master 2 write, slave never answers: err on the 5th strobe cycle only
        m_cyc = 3'b100;
        m_stb = 3'b100;
        m_we  = 3'b100;
        m_adr[95:64]   = 32'h0000_0100;
        m_dat_w[95:64] = 32'h1234_5678;
        m_sel[11:8]    = 4'hF;
        step();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("tmo_m_err", 32'(m_err), (k == 4) ? 32'b100 : 32'd0);
            check("tmo_s_cyc", 32'(s_cyc), 32'd1);
            step();
        end
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        step();

        // Master 0: ack lands in the limit cycle, then the count restarts from zero
        m_cyc = 3'b001;
        m_stb = 3'b001;
        step();
        for (int k = 0; k < 10; k++) begin
            s_ack = (k == 4);
            @(negedge clk);
            check("lim_m_ack", 32'(m_ack), (k == 4) ? 32'b001 : 32'd0);
            check("lim_m_err", 32'(m_err), (k == 9) ? 32'b001 : 32'd0);
            step();
        end
        s_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        step();

        // Master 0 holds a 4-beat write burst while master 1 waits
        m_cyc = 3'b001;
        m_stb = 3'b001;
        m_we  = 3'b001;
        step();
        m_cyc = 3'b011;
        m_stb = 3'b011;
        for (int b = 0; b < 4; b++) begin
            m_adr[31:0]   = 32'h0000_0200 + 32'(4 * b);
            m_dat_w[31:0] = 32'h0000_00A0 + 32'(b);
            s_ack = 1'b1;
            @(negedge clk);
            check("bst_grant", 32'(grant), 32'd0);
            check("bst_m_ack", 32'(m_ack), 32'b001);
            step();
        end
        s_ack = 1'b0;
        m_cyc = 3'b010;
        m_stb = 3'b010;
        m_we  = '0;
        @(negedge clk);
        check("bst_drop_busy",  32'(busy),  32'd1);
        check("bst_drop_grant", 32'(grant), 32'd0);
        step();
        @(negedge clk);
        check("bst_gap_busy",  32'(busy),  32'd0);
        check("bst_gap_s_cyc", 32'(s_cyc), 32'd0);
        step();
        @(negedge clk);
        check("bst_next_busy",  32'(busy),  32'd1);
        check("bst_next_grant", 32'(grant), 32'd1);

        // Reset pulse while master 1 has a strobe outstanding
        step();
        rst   = 1'b0;
        m_cyc = 3'b011;
        step();
        rst   = 1'b1;
        m_stb = '0;
        @(negedge clk);
        check("mrst_busy",  32'(busy),  32'd0);
        check("mrst_grant", 32'(grant), 32'd0);
        check("mrst_s_cyc", 32'(s_cyc), 32'd0);
        check("mrst_m_ack", 32'(m_ack), 32'd0);
        check("mrst_m_err", 32'(m_err), 32'd0);
        step();
        @(negedge clk);
        check("mrst_first_busy",  32'(busy),  32'd1);
        check("mrst_first_grant", 32'(grant), 32'd0);
        step();
        m_cyc = '0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
